lbist_ctrl: RTL and testbench

LBIST_CTRL -- requirements
Module: lbist_ctrl

---
 rtl/lbist_pkg.sv | 8 +
 rtl/lbist_pat_cnt.sv | 21 ++
 rtl/lbist_ctrl.sv | 119 +++++++++++
 tb/tb_lbist_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lbist_pkg.sv
// Shared types and defaults for the logic-BIST run controller.
package lbist_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FILL, S_RUN, S_FLUSH, S_CMP, S_DONE
  } state_t;

  localparam int FILL_LAT_DEF = 2;
endpackage

// File: rtl/lbist_pat_cnt.sv
// Loadable down-counter with a zero flag; times both generator fill and the pattern run.
module lbist_pat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] din,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (load) cnt <= din;
    else if (dec)  cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST run sequencer: reset TPG/MISR, wait for fill, apply N patterns, compare signature.
// Optional abort input is built in when LBIST_ABORT_EN is defined.
module lbist_ctrl import lbist_pkg::*; #(
  parameter int OUT_BITS = 4,
  parameter int SIG_BITS = 4,
  parameter int CNT_W    = 8,
  parameter int FILL_LAT = FILL_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_patterns,
  input  logic [SIG_BITS-1:0] golden_sig,
  input  logic [SIG_BITS-1:0] misr_sig,
`ifdef LBIST_ABORT_EN
  input  logic                abort,
`endif
  output logic                tpg_rst,
  output logic                misr_clr,
  output logic                misr_en,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail
);
  if (OUT_BITS < 1 || FILL_LAT < 1 || FILL_LAT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("lbist_ctrl: unsupported OUT_BITS/FILL_LAT/CNT_W combination");
  end

  state_t              state, nxt;
  logic [CNT_W-1:0]    n_q;
  logic [SIG_BITS-1:0] gold_q;
  logic                abt, pat_load, pat_dec, pat_zero, fill_load, fill_dec, fill_zero;

`ifdef LBIST_ABORT_EN
  assign abt = abort;
`else
  assign abt = 1'b0;
`endif

  // Counters are preloaded with length-1 so that "zero" marks the last cycle.
  lbist_pat_cnt #(.CNT_W(CNT_W)) u_pat (
    .clk(clk), .rst(rst), .load(pat_load), .din(n_q - CNT_W'(1)),
    .dec(pat_dec), .zero(pat_zero)
  );

  lbist_pat_cnt #(.CNT_W(CNT_W)) u_fill (
    .clk(clk), .rst(rst), .load(fill_load), .din(CNT_W'(FILL_LAT - 1)),
    .dec(fill_dec), .zero(fill_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    pat_load  = 1'b0;
    pat_dec   = 1'b0;
    fill_load = 1'b0;
    fill_dec  = 1'b0;
    tpg_rst   = 1'b0;
    misr_clr  = 1'b0;
    misr_en   = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start && !abt) nxt = S_INIT;
      S_INIT: begin
        tpg_rst   = 1'b1;
        misr_clr  = 1'b1;
        pat_load  = 1'b1;
        fill_load = 1'b1;
        nxt       = S_FILL;
      end
      S_FILL: begin
        if (fill_zero) nxt = (n_q == '0) ? S_FLUSH : S_RUN;
        else           fill_dec = 1'b1;
      end
      S_RUN: begin
        misr_en = 1'b1;
        if (pat_zero) nxt = S_FLUSH;
        else          pat_dec = 1'b1;
      end
      S_FLUSH: nxt = S_CMP;
      S_CMP:   nxt = S_DONE;
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (abt && state != S_IDLE) nxt = S_IDLE;
  end

  // start+abort together in IDLE is refused but still clears stale results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q    <= '0;
      gold_q <= '0;
      pass   <= 1'b0;
      fail   <= 1'b0;
    end else if (state == S_IDLE && start) begin
      pass <= 1'b0;
      fail <= 1'b0;
      if (!abt) begin
        n_q    <= num_patterns;
        gold_q <= golden_sig;
      end
    end else if (abt && state != S_IDLE) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (state == S_CMP) begin
      pass <= (misr_sig == gold_q);
      fail <= (misr_sig != gold_q);
    end
  end
endmodule

// File: tb/tb_lbist_ctrl.sv
// Scoreboard bench for lbist_ctrl: stimulus queues expected results, monitor checks at each done.
module tb_lbist_ctrl;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [7:0] num_patterns = '0;
  logic [3:0] golden_sig = '0, misr_sig = '0;
`ifdef LBIST_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic tpg_rst, misr_clr, misr_en, busy, done, pass, fail;

  lbist_ctrl #(.OUT_BITS(4), .SIG_BITS(4), .CNT_W(8), .FILL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
    .golden_sig(golden_sig), .misr_sig(misr_sig),
`ifdef LBIST_ABORT_EN
    .abort(abort),
`endif
    .tpg_rst(tpg_rst), .misr_clr(misr_clr), .misr_en(misr_en), .busy(busy),
    .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit p; bit f; int en; int dcyc; } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0;

  task automatic chk(string nm, int act, int req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: count strobes per run, compare against the queued expectation at done.
  int en_c = 0, tpg_c = 0, clr_c = 0;
  bit done_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst || !busy) begin
      en_c = 0; tpg_c = 0; clr_c = 0;
    end else begin
      en_c += int'(misr_en); tpg_c += int'(tpg_rst); clr_c += int'(misr_clr);
    end
    if (done_d) chk("done_width", int'(done), 0);
    if (pass && fail) chk("pass_fail_excl", 1, 0);
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("pass", int'(pass), int'(e.p));
        chk("fail", int'(fail), int'(e.f));
        chk("misr_en_cycles", en_c, e.en);
        chk("tpg_rst_cycles", tpg_c, 1);
        chk("misr_clr_cycles", clr_c, 1);
        chk("done_cycle", cyc, e.dcyc);
      end
    end
    done_d = done;
  end

  task automatic run_vec(int n, logic [3:0] g, logic [3:0] s, bit push);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 1, 0);
    start = 1'b1; num_patterns = 8'(n); golden_sig = g; misr_sig = s;
    if (push) q.push_back('{(g == s), (g != s), n, cyc + 6 + n});
    @(posedge clk); #1;
    start = 1'b0;
    chk("init_flags_clear", int'({pass, fail}), 0);
    chk("init_tpg_rst", int'(tpg_rst), 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({tpg_rst, misr_clr, misr_en, done, pass, fail}), 0);
    rst = 1'b1;

    run_vec(5, 4'h3, 4'h3, 1'b1);     // N=5 match, done 11 cycles after start
    run_vec(3, 4'hA, 4'h5, 1'b1);     // back-to-back, mismatch
    run_vec(0, 4'h7, 4'h7, 1'b1);     // N=0 bypasses RUN
    run_vec(0, 4'h7, 4'h6, 1'b1);
    run_vec(1, 4'hF, 4'hF, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("flags_held", int'({pass, fail}), 2);

    // Mid-run re-start and operand changes must be ignored.
    run_vec(8, 4'hC, 4'hC, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; num_patterns = 8'd2; golden_sig = 4'h1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Reset during the third RUN cycle of a 10-pattern run.
    run_vec(10, 4'h9, 4'h9, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_misr_en", int'(misr_en), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_outs", int'({tpg_rst, misr_clr, misr_en, done, pass, fail}), 0);
    @(posedge clk); #3 rst = 1'b1;
    run_vec(10, 4'h9, 4'h9, 1'b1);
    drain();

`ifdef LBIST_ABORT_EN
    run_vec(4, 4'h2, 4'h2, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outs", int'({misr_en, tpg_rst, done, pass, fail}), 0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_flags", int'({pass, fail}), 0);
`else
    run_vec(4, 4'h2, 4'h2, 1'b1);
`endif
    drain();
    repeat (15) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
